mul_dot_seq: RTL and testbench
==============================

# mul_dot_seq

Operand sequencer and accumulator that sits directly upstream of the 8x8 sequential multiplier (start/ready handshake, 16-bit product).
- Accepts a stream of 8-bit operand pairs through a valid/ready input and buffers them in a small FIFO.
- Issues one multiplier job per pair and captures each 16-bit product.
- Accumulates the products into a dot-product sum, which it presents on a valid/ready output when the pair tagged `last` has been accumulated.

## Interface
- `ACC_W`, 20: accumulator and `out_sum` width (>=16).
- `DEPTH`, 4: operand FIFO depth (power of two, >=2).
- `GUARD`, 10: cycles after reset release before the first multiplier job may issue.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO not full. Pair is pushed on `in_valid && in_ready`.
- `in_a` in 8: multiplicand.
- `in_b` in 8: multiplier operand.
- `in_last` in 1: marks the final pair of a vector.
- `mul_start` out 1: one-cycle job pulse to the multiplier.
- `mul_a` out 8: registered operand to the multiplier, stable from the `mul_start` cycle until the next issue.
- `mul_b` out 8: as `mul_a`.
- `mul_ready` in 1: multiplier result strobe. `mul_m` is valid in the cycle it is high.
- `mul_m` in 16: multiplier product.
- `out_valid` out 1: sum available.
- `out_ready` in 1: consumer accepts. Transfer happens on `out_valid && out_ready`.
- `out_sum` out ACC_W: accumulated sum, modulo 2^ACC_W.
- `out_count` out 8: number of products in the sum, saturating at 255.
- `out_ovf` out 1: sticky. Set if any accumulation carried out of ACC_W bits.

## Operation
- The FIFO stores {last, a, b}, 17 bits per entry.
- Push is gated only by `in_ready`; there is no pass-through when the FIFO is full.
- Push and pop in the same cycle are both performed, and occupancy is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty and the guard counter is expired, pop the head into `mul_a`/`mul_b`/last_r, register `mul_start`=1, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: `mul_start`=0.
    - On `mul_ready`=1: `acc <= acc + {0, mul_m}`; `ovf |= carry`; `count <= min(count+1, 255)`.
    - Then go to OUT if last_r is set, otherwise to IDLE.
  - OUT: `out_valid`=1, with `out_sum`/`out_count`/`out_ovf` driven from acc/count/ovf and held stable. On `out_ready`, clear acc, count and ovf, then go to IDLE.
- `mul_ready` sampled in IDLE or OUT is ignored: no accumulation and no state change.
- `mul_start` is never high on two consecutive cycles, and never high outside the IDLE->WAIT transition.
- The multiplier requires a single-cycle start with operands valid in that cycle.
- The input FIFO keeps accepting pairs in every state, including OUT.
- Reset, synchronous, at any point:
  - FIFO emptied; FSM goes to IDLE.
  - acc, count and ovf cleared.
  - Guard counter loaded with GUARD.
  - All outputs 0: `in_ready`=0 during reset, then 1 on the first cycle after release.
- Guard counter: decrements once per cycle down to 0. Issue is blocked while it is non-zero. This lets a multiplier job still in flight at reset finish; its stray `mul_ready` then lands in IDLE and is ignored.

## Timing
- Registered outputs: `mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_sum`, `out_count`, `out_ovf`.
- `in_ready` is combinational from FIFO occupancy only.
- Empty FIFO: a push in cycle t gives a non-empty FIFO in t+1 and `mul_start` high in t+2 (guard expired).
- With the 8-cycle multiplier, `mul_ready` arrives 9 cycles after the `mul_start` cycle. The block must not depend on that number and must wait on `mul_ready`.
- Accumulation happens at the edge ending the `mul_ready` cycle.
  - If the FIFO is non-empty, the next `mul_start` follows 2 cycles after the `mul_ready` cycle.
  - For a last pair, `out_valid` is high 1 cycle after the `mul_ready` cycle.
- Sustained period per pair with the 8-cycle multiplier: 11 cycles.
- `out_valid` stays high with data frozen while `out_ready`=0. After acceptance, `out_valid`=0 in the next cycle.

## Test plan
- Single pair: a=3, b=5, last=1, with a model multiplier of 9-cycle latency -> one `mul_start` pulse, `mul_a`=3, `mul_b`=5; then `out_sum`=15, `out_count`=1, `out_ovf`=0.
- Four pairs of (255,255) pushed back-to-back, the fourth with last=1 -> `in_ready` stays 1; four `mul_start` pulses spaced 11 cycles apart; `out_sum`=260100, `out_count`=4.
- Overflow: ACC_W=20, 17 pairs of (255,255) -> `out_ovf`=1, `out_sum`=56849 (1105425 mod 2^20), `out_count`=17.
- Backpressure:
  - Hold `out_ready`=0 for 30 cycles while pushing 6 pairs -> `out_valid` held with `out_sum` stable.
  - FIFO fills to 4 and `in_ready`=0.
  - Release -> one transfer, then the next vector starts from acc=0.
- Reset mid-WAIT, with the multiplier model still busy -> all outputs 0. The stray `mul_ready` 5 cycles later is ignored (acc stays 0, no state change). The first new `mul_start` appears no earlier than GUARD cycles after release.
- Spurious `mul_ready`=1 with `mul_m`=0xFFFF in IDLE and in OUT -> acc, count and state unchanged.

Source files
------------

// File: rtl/mul_dot_seq.sv
// Operand FIFO, multiplier job sequencer and dot-product accumulator
// sitting in front of an 8x8 start/ready sequential multiplier.
module mul_dot_seq #(
    parameter int ACC_W = 20,
    parameter int DEPTH = 4,
    parameter int GUARD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic             mul_ready,
    input  logic [15:0]      mul_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(GUARD + 2);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [16:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             push, pop;
    logic [16:0]      head;

    logic             mul_start_q, mul_start_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic             last_q, last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W:0]   sum;

    // in_ready is forced low while reset is asserted
    assign in_ready = !rst && (occ_q != FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign sum      = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, mul_m};

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        guard_d = (guard_q != '0) ? guard_q - 1'b1 : guard_q;
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        last_d      = last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (occ_q != '0 && guard_q == '0) begin
                    pop                       = 1'b1;
                    {last_d, mul_a_d, mul_b_d} = head;
                    mul_start_d               = 1'b1;
                    state_d                   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_ready) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (last_q) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            guard_q     <= GW'(GUARD);
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            guard_q     <= guard_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // storage needs no reset; push is already blocked during reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_a, in_b};
        end
    end

endmodule

// File: tb/tb_mul_dot_seq.sv
// Directed bench for mul_dot_seq: 9-cycle multiplier model, pair/vector
// scoreboard checked every cycle, plus literal expectations per scenario.
module tb_mul_dot_seq;

    localparam int ACC_W = 20;
    localparam int GUARD = 10;
    localparam int LAT   = 9;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             mul_start;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic             mul_ready;
    logic [15:0]      mul_m;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    logic             spur_req;
    logic [15:0]      spur_m;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          last_push_cyc = 0;
    int          rel_cyc = 0;
    int          starts[$];
    logic [16:0] iq[$];
    longint      eq_sum[$];
    int          eq_n[$];
    longint      run_sum = 0;
    int          run_n = 0;
    logic        prev_rst = 1'b1;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    longint      held_sum = 0;
    longint      held_cnt = 0;
    longint      held_ovf = 0;

    int          mdly = 0;
    logic [15:0] mprod = '0;

    mul_dot_seq #(.ACC_W(ACC_W), .DEPTH(4), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_m     (mul_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Multiplier: result strobe LAT cycles after the start cycle
    initial begin
        mul_ready = 1'b0;
        mul_m     = '0;
        forever begin
            @(posedge clk);
            #2;
            mul_ready = 1'b0;
            mul_m     = '0;
            if (mdly > 0) begin
                mdly--;
                if (mdly == 0) begin
                    mul_ready = 1'b1;
                    mul_m     = mprod;
                end
            end
            if (spur_req) begin
                mul_ready = 1'b1;
                mul_m     = spur_m;
            end
            if (mul_start) begin
                mdly  = LAT;
                mprod = {8'd0, mul_a} * {8'd0, mul_b};
            end
        end
    end

    task automatic monitor_step();
        logic [16:0] p;
        longint      s;
        int          n;
        cyc++;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            iq.delete();
            eq_sum.delete();
            eq_n.delete();
            run_sum    = 0;
            run_n      = 0;
            prev_start = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_rst) rel_cyc = cyc;
            if (in_valid && in_ready) begin
                iq.push_back({in_last, in_a, in_b});
                run_sum += longint'(in_a) * longint'(in_b);
                run_n++;
                last_push_cyc = cyc;
                if (in_last) begin
                    eq_sum.push_back(run_sum);
                    eq_n.push_back(run_n);
                    run_sum = 0;
                    run_n   = 0;
                end
            end
            if (mul_start) begin
                starts.push_back(cyc);
                chk("start_back_to_back", prev_start, 0);
                chk("start_pending", iq.size() > 0, 1);
                if (iq.size() > 0) begin
                    p = iq.pop_front();
                    chk("mul_a", mul_a, p[15:8]);
                    chk("mul_b", mul_b, p[7:0]);
                end
            end
            if (prev_valid && prev_ready) begin
                chk("valid_after_xfer", out_valid, 0);
            end else if (prev_valid) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, held_sum);
                chk("hold_count", out_count, held_cnt);
                chk("hold_ovf", out_ovf, held_ovf);
            end
            if (out_valid && out_ready) begin
                chk("out_pending", eq_sum.size() > 0, 1);
                if (eq_sum.size() > 0) begin
                    s = eq_sum.pop_front();
                    n = eq_n.pop_front();
                    chk("model_sum", out_sum, s % (longint'(1) << ACC_W));
                    chk("model_count", out_count, (n > 255) ? 255 : n);
                    chk("model_ovf", out_ovf, s >= (longint'(1) << ACC_W));
                end
            end
            prev_start = mul_start;
            prev_valid = out_valid;
            prev_ready = out_ready;
            held_sum   = out_sum;
            held_cnt   = out_count;
            held_ovf   = out_ovf;
        end
        prev_rst = rst;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic last, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("push_timeout", waited, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < maxc) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_timeout", out_valid, 1);
    endtask

    task automatic wait_start(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!mul_start && n < maxc) begin
            n++;
            @(negedge clk);
        end
        if (!mul_start) chk("start_timeout", mul_start, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int s0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        spur_req  = 1'b0;
        spur_m    = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {mul_start, mul_a, mul_b, out_valid,
                         out_sum, out_count, out_ovf}, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_release", in_ready, 1);
        repeat (12) step();

        // single pair
        push(8'd3, 8'd5, 1'b1, w);
        wait_out(100);
        chk("t1_sum", out_sum, 15);
        chk("t1_count", out_count, 1);
        chk("t1_ovf", out_ovf, 0);
        chk("t1_starts", starts.size(), 1);
        chk("t1_latency", starts[0] - last_push_cyc, 2);
        chk("t1_mul_a", mul_a, 3);
        chk("t1_mul_b", mul_b, 5);
        step();

        // four max pairs back-to-back
        s0 = starts.size();
        for (int i = 0; i < 4; i++) begin
            push(8'd255, 8'd255, i == 3, w);
            chk("t2_in_ready", w, 0);
        end
        wait_out(200);
        chk("t2_sum", out_sum, 260100);
        chk("t2_count", out_count, 4);
        chk("t2_starts", starts.size() - s0, 4);
        for (int k = 0; k < 3; k++) begin
            if (starts.size() > s0 + k + 1)
                chk("t2_period", starts[s0+k+1] - starts[s0+k], 11);
        end
        step();

        // accumulator overflow
        for (int i = 0; i < 17; i++) begin
            push(8'd255, 8'd255, i == 16, w);
        end
        wait_out(400);
        chk("t3_ovf", out_ovf, 1);
        chk("t3_sum", out_sum, 56849);
        chk("t3_count", out_count, 17);
        step();

        // output backpressure with FIFO filling
        out_ready = 1'b0;
        push(8'd10, 8'd20, 1'b1, w);
        wait_out(100);
        step();
        fork
            begin
                push(8'd1, 8'd2, 1'b0, w);
                push(8'd3, 8'd4, 1'b0, w);
                push(8'd5, 8'd6, 1'b0, w);
                push(8'd7, 8'd8, 1'b1, w);
                push(8'd9, 8'd10, 1'b0, w);
                push(8'd11, 8'd12, 1'b1, w);
            end
            begin
                repeat (20) @(negedge clk);
                chk("t4_full", in_ready, 0);
                chk("t4_valid", out_valid, 1);
                chk("t4_sum", out_sum, 200);
                repeat (10) @(negedge clk);
                chk("t4_sum_late", out_sum, 200);
                step();
                out_ready = 1'b1;
            end
        join
        wait_out(200);
        chk("t4_next_sum", out_sum, 100);
        chk("t4_next_count", out_count, 4);
        step();
        wait_out(200);
        chk("t4_last_sum", out_sum, 222);
        chk("t4_last_count", out_count, 2);
        step();

        // reset while the multiplier is busy
        push(8'd200, 8'd100, 1'b1, w);
        wait_start(50);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_outs", {mul_start, mul_a, mul_b, out_valid,
                        out_sum, out_count, out_ovf}, 0);
        chk("t5_in_ready", in_ready, 1);
        step();
        s0 = starts.size();
        push(8'd2, 8'd3, 1'b1, w);
        wait_out(200);
        chk("t5_sum", out_sum, 6);
        chk("t5_count", out_count, 1);
        chk("t5_starts", starts.size() - s0, 1);
        if (starts.size() > s0)
            chk("t5_guard", starts[s0] - rel_cyc >= GUARD, 1);
        step();

        // spurious strobe in IDLE, then in OUT
        push(8'd4, 8'd4, 1'b0, w);
        wait_start(50);
        repeat (12) step();
        spur_req = 1'b1;
        spur_m   = 16'hFFFF;
        step();
        spur_req  = 1'b0;
        out_ready = 1'b0;
        push(8'd5, 8'd5, 1'b1, w);
        wait_out(100);
        chk("t6_sum", out_sum, 41);
        chk("t6_count", out_count, 2);
        step();
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_out_valid", out_valid, 1);
        chk("t6_out_sum", out_sum, 41);
        chk("t6_out_count", out_count, 2);
        step();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_drained", out_valid, 0);
        chk("t6_no_start", mul_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
